// File: rtl/mem_access_unit.sv
// MEM-stage load/store bus engine: 4-cycle minimum (accept, REQ, WAIT, DONE), stalls upstream until done.
// Optional MAU_ALIGN_CHECK_EN faults misaligned half/word accesses straight to DONE with mem_ale.
module mem_access_unit (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        mem_valid,
    input  logic        mem_re,
    input  logic [3:0]  ram_we,
    input  logic [2:0]  ram_ext_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        mem_ale,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam logic [3:0] RAM_WE_N  = 4'b0000;
    localparam logic [3:0] RAM_WE_B  = 4'b0001;
    localparam logic [3:0] RAM_WE_H  = 4'b0011;
    localparam logic [3:0] RAM_WE_W  = 4'b1111;

    localparam logic [2:0] RAM_EXT_N  = 3'd0;
    localparam logic [2:0] RAM_EXT_B  = 3'd1;
    localparam logic [2:0] RAM_EXT_BU = 3'd2;
    localparam logic [2:0] RAM_EXT_H  = 3'd3;
    localparam logic [2:0] RAM_EXT_HU = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  ext_q, ext_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        is_wr_in;
    logic [1:0]  off_in;
    logic [3:0]  strb_in;
    logic [31:0] wdata_in;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic        fault;

`ifdef MAU_ALIGN_CHECK_EN
    logic        ale_q, ale_d;
`endif

    // Request decode from the live MEM-stage inputs; only used on the accepting cycle.
    always_comb begin
        accept   = mem_valid & (mem_re | (ram_we != RAM_WE_N));
        is_wr_in = (ram_we != RAM_WE_N);
        off_in   = mem_addr[1:0];
        strb_in  = ram_we << off_in;
        case (ram_we)
            RAM_WE_B: wdata_in = {4{mem_wdata[7:0]}};
            RAM_WE_H: wdata_in = {2{mem_wdata[15:0]}};
            default:  wdata_in = mem_wdata;
        endcase
`ifdef MAU_ALIGN_CHECK_EN
        if (is_wr_in) begin
            fault = ((ram_we == RAM_WE_H) & off_in[0]) |
                    ((ram_we == RAM_WE_W) & (off_in != 2'b00));
        end else begin
            fault = (((ram_ext_op == RAM_EXT_H) | (ram_ext_op == RAM_EXT_HU)) & off_in[0]) |
                    ((ram_ext_op == RAM_EXT_N) & (off_in != 2'b00));
        end
`else
        fault = 1'b0;
`endif
    end

    // Lane extraction of the returned word using the latched offset and extension code.
    always_comb begin
        byte_sel = data_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (ext_q)
            RAM_EXT_B:  load_val = {{24{byte_sel[7]}}, byte_sel};
            RAM_EXT_BU: load_val = {24'h0, byte_sel};
            RAM_EXT_H:  load_val = {{16{half_sel[15]}}, half_sel};
            RAM_EXT_HU: load_val = {16'h0, half_sel};
            default:    load_val = data_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        off_d     = off_q;
        ext_d     = ext_q;
        rdata_d   = rdata_q;
        mem_stall = 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
        ale_d     = ale_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_stall = 1'b1;
                    wr_d      = is_wr_in;
                    wstrb_d   = is_wr_in ? strb_in : 4'b0000;
                    addr_d    = {mem_addr[31:2], 2'b00};
                    wdata_d   = is_wr_in ? wdata_in : 32'h0;
                    off_d     = off_in;
                    ext_d     = ram_ext_op;
`ifdef MAU_ALIGN_CHECK_EN
                    ale_d     = fault;
`endif
                    state_d   = fault ? DONE : REQ;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (data_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (data_data_ok) begin
                    rdata_d = wr_q ? 32'h0 : load_val;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            wstrb_q <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            off_q   <= 2'b00;
            ext_q   <= RAM_EXT_N;
            rdata_q <= 32'h0;
`ifdef MAU_ALIGN_CHECK_EN
            ale_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            ext_q   <= ext_d;
            rdata_q <= rdata_d;
`ifdef MAU_ALIGN_CHECK_EN
            ale_q   <= ale_d;
`endif
        end
    end

    assign data_req   = (state_q == REQ);
    assign data_wr    = wr_q;
    assign data_wstrb = wstrb_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign mem_rdata  = rdata_q;
    assign mem_done   = (state_q == DONE);
`ifdef MAU_ALIGN_CHECK_EN
    assign mem_ale    = (state_q == DONE) & ale_q;
`else
    assign mem_ale    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store vectors plus reset-abort and alignment sequences.
module tb_mem_access_unit;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        mem_valid;
    logic        mem_re;
    logic [3:0]  ram_we;
    logic [2:0]  ram_ext_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic        mem_ale;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 cpu_clk = ~cpu_clk;

    mem_access_unit dut (
        .cpu_clk      (cpu_clk),
        .cpu_rst      (cpu_rst),
        .mem_valid    (mem_valid),
        .mem_re       (mem_re),
        .ram_we       (ram_we),
        .ram_ext_op   (ram_ext_op),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .mem_stall    (mem_stall),
        .mem_ale      (mem_ale),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    typedef struct {
        logic        re;
        logic [3:0]  we;
        logic [2:0]  ext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          adly;
        int          ddly;
        logic        exp_wr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic re, input logic [3:0] we, input logic [2:0] ext,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int adly, input int ddly,
                                 input logic exp_wr, input logic [3:0] exp_strb,
                                 input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                                 input logic [31:0] exp_rdata);
        vec_t v;
        v.re = re; v.we = we; v.ext = ext; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.adly = adly; v.ddly = ddly; v.exp_wr = exp_wr; v.exp_strb = exp_strb;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // One full transaction; bus handshakes arrive after adly/ddly extra cycles.
    task automatic run_txn(input vec_t v, input string tag);
        @(negedge cpu_clk);
        mem_valid = 1'b1; mem_re = v.re; ram_we = v.we; ram_ext_op = v.ext;
        mem_addr = v.addr; mem_wdata = v.wdata;
        #1;
        chk({tag, "_stall_accept"}, mem_stall, 1);
        chk({tag, "_req_accept"}, data_req, 0);
        for (int c = 0; c <= v.adly; c++) begin
            @(negedge cpu_clk);
            mem_addr = ~v.addr; mem_wdata = ~v.wdata; ram_we = 4'b0001; mem_re = 1'b1;
            ram_ext_op = 3'd1;
            data_addr_ok = (c == v.adly);
            #1;
            chk($sformatf("%s_req_c%0d", tag, c), data_req, 1);
            chk($sformatf("%s_wr_c%0d", tag, c), data_wr, v.exp_wr);
            chk($sformatf("%s_strb_c%0d", tag, c), data_wstrb, v.exp_strb);
            chk($sformatf("%s_addr_c%0d", tag, c), data_addr, v.exp_addr);
            chk($sformatf("%s_wdata_c%0d", tag, c), data_wdata, v.exp_wdata);
            chk($sformatf("%s_stall_req_c%0d", tag, c), mem_stall, 1);
            chk($sformatf("%s_done_req_c%0d", tag, c), mem_done, 0);
        end
        for (int c = 0; c <= v.ddly; c++) begin
            @(negedge cpu_clk);
            data_addr_ok = 1'b0;
            data_data_ok = (c == v.ddly);
            data_rdata   = (c == v.ddly) ? v.rdata : 32'hDEAD_0BAD;
            #1;
            chk($sformatf("%s_req_wait_c%0d", tag, c), data_req, 0);
            chk($sformatf("%s_stall_wait_c%0d", tag, c), mem_stall, 1);
            chk($sformatf("%s_done_wait_c%0d", tag, c), mem_done, 0);
        end
        @(negedge cpu_clk);
        data_data_ok = 1'b0; data_rdata = 32'h0; mem_valid = 1'b0;
        #1;
        chk({tag, "_done"}, mem_done, 1);
        chk({tag, "_stall_done"}, mem_stall, 0);
        chk({tag, "_rdata"}, mem_rdata, v.exp_rdata);
        chk({tag, "_ale"}, mem_ale, 0);
        @(negedge cpu_clk);
        #1;
        chk({tag, "_done_once"}, mem_done, 0);
        chk({tag, "_rdata_hold"}, mem_rdata, v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        cpu_rst = 1'b1; mem_valid = 1'b0; mem_re = 1'b0; ram_we = 4'b0; ram_ext_op = 3'd0;
        mem_addr = 32'h0; mem_wdata = 32'h0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = 32'h0;

        //     re  we       ext   addr          wdata         rdata         ad dd wr strb     addr          wdata         rdata
        vecs.push_back(mkv(0, 4'b1111, 3'd0, 32'h1000_0004, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 1, 4'b1111, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mkv(0, 4'b0001, 3'd0, 32'h1000_0003, 32'h0000_00A5, 32'h0,         0, 0, 1, 4'b1000, 32'h1000_0000, 32'hA5A5_A5A5, 32'h0));
        vecs.push_back(mkv(1, 4'b0000, 3'd1, 32'h1000_0002, 32'h0,         32'h1280_3344, 3, 2, 0, 4'b0000, 32'h1000_0000, 32'h0,         32'hFFFF_FF80));
        vecs.push_back(mkv(1, 4'b0000, 3'd2, 32'h1000_0002, 32'h0,         32'h1280_3344, 0, 0, 0, 4'b0000, 32'h1000_0000, 32'h0,         32'h0000_0080));
        vecs.push_back(mkv(1, 4'b0000, 3'd3, 32'h1000_0002, 32'h0,         32'h8001_7FFF, 1, 0, 0, 4'b0000, 32'h1000_0000, 32'h0,         32'hFFFF_8001));
        vecs.push_back(mkv(1, 4'b0000, 3'd4, 32'h1000_0002, 32'h0,         32'h8001_7FFF, 0, 1, 0, 4'b0000, 32'h1000_0000, 32'h0,         32'h0000_8001));
        vecs.push_back(mkv(1, 4'b0000, 3'd3, 32'h1000_0000, 32'h0,         32'h8001_7FFF, 0, 0, 0, 4'b0000, 32'h1000_0000, 32'h0,         32'h0000_7FFF));
        vecs.push_back(mkv(0, 4'b0011, 3'd0, 32'h1000_0002, 32'hCAFE_1234, 32'h0,         0, 0, 1, 4'b1100, 32'h1000_0000, 32'h1234_1234, 32'h0));
        vecs.push_back(mkv(1, 4'b0000, 3'd0, 32'h2000_0008, 32'h0,         32'h89AB_CDEF, 0, 0, 0, 4'b0000, 32'h2000_0008, 32'h0,         32'h89AB_CDEF));
        vecs.push_back(mkv(1, 4'b0000, 3'd2, 32'h2000_0001, 32'h0,         32'h0000_C300, 0, 0, 0, 4'b0000, 32'h2000_0000, 32'h0,         32'h0000_00C3));
        vecs.push_back(mkv(1, 4'b0000, 3'd1, 32'h2000_0003, 32'h0,         32'h7F00_0000, 0, 0, 0, 4'b0000, 32'h2000_0000, 32'h0,         32'h0000_007F));
        vecs.push_back(mkv(1, 4'b1111, 3'd0, 32'h2000_000C, 32'h0102_0304, 32'hFFFF_FFFF, 0, 0, 1, 4'b1111, 32'h2000_000C, 32'h0102_0304, 32'h0));
        vecs.push_back(mkv(1, 4'b0000, 3'd1, 32'h2000_0000, 32'h0,         32'h0000_00F0, 0, 0, 0, 4'b0000, 32'h2000_0000, 32'h0,         32'hFFFF_FFF0));
`ifndef MAU_ALIGN_CHECK_EN
        vecs.push_back(mkv(0, 4'b0011, 3'd0, 32'h4000_0003, 32'h0000_BEEF, 32'h0,         0, 0, 1, 4'b1000, 32'h4000_0000, 32'hBEEF_BEEF, 32'h0));
        vecs.push_back(mkv(1, 4'b0000, 3'd0, 32'h4000_0002, 32'h0,         32'h1357_9BDF, 0, 0, 0, 4'b0000, 32'h4000_0000, 32'h0,         32'h1357_9BDF));
`endif

        repeat (2) @(negedge cpu_clk);
        #1;
        chk("rst_req", data_req, 0);
        chk("rst_wr", data_wr, 0);
        chk("rst_done", mem_done, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_ale", mem_ale, 0);
        chk("rst_strb", data_wstrb, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_rdata", mem_rdata, 0);

        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        mem_valid = 1'b1; mem_re = 1'b0; ram_we = 4'b0000;
        #1;
        chk("noop_stall", mem_stall, 0);
        @(negedge cpu_clk);
        mem_valid = 1'b0; mem_re = 1'b1;
        #1;
        chk("noop_req", data_req, 0);
        chk("invalid_stall", mem_stall, 0);
        @(negedge cpu_clk);
        mem_re = 1'b0;
        #1;
        chk("invalid_req", data_req, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while waiting for data: the late data_ok must not complete anything.
        @(negedge cpu_clk);
        mem_valid = 1'b1; mem_re = 1'b1; ram_we = 4'b0; ram_ext_op = 3'd0; mem_addr = 32'h3000_0000;
        @(negedge cpu_clk);
        mem_valid = 1'b0; data_addr_ok = 1'b1;
        @(negedge cpu_clk);
        data_addr_ok = 1'b0; cpu_rst = 1'b1;
        #1;
        chk("abort_in_wait_req", data_req, 0);
        chk("abort_in_wait_stall", mem_stall, 1);
        @(negedge cpu_clk);
        cpu_rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
        #1;
        chk("abort_req", data_req, 0);
        chk("abort_stall", mem_stall, 0);
        chk("abort_done", mem_done, 0);
        chk("abort_rdata", mem_rdata, 0);
        @(negedge cpu_clk);
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        chk("abort_done_late", mem_done, 0);
        chk("abort_rdata_late", mem_rdata, 0);
        chk("abort_req_late", data_req, 0);

        run_txn(vecs[2], "recover");

`ifdef MAU_ALIGN_CHECK_EN
        @(negedge cpu_clk);
        mem_valid = 1'b1; mem_re = 1'b1; ram_we = 4'b0; ram_ext_op = 3'd0; mem_addr = 32'h4000_0002;
        #1;
        chk("ale_stall_accept", mem_stall, 1);
        chk("ale_pre", mem_ale, 0);
        @(negedge cpu_clk);
        mem_valid = 1'b0;
        #1;
        chk("ale_done", mem_done, 1);
        chk("ale_flag", mem_ale, 1);
        chk("ale_req", data_req, 0);
        chk("ale_stall", mem_stall, 0);
        chk("ale_rdata_hold", mem_rdata, 32'hFFFF_FF80);
        @(negedge cpu_clk);
        #1;
        chk("ale_done_once", mem_done, 0);
        chk("ale_flag_once", mem_ale, 0);
        chk("ale_req_after", data_req, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Responder for the CU memory-control outputs (`ram_we`, `ram_ext_op`) in the MEM stage. It turns one decoded load or store into a single SRAM-like bus transaction. For stores it generates byte strobes and lane-replicated write data. For loads it selects the addressed byte or halfword and sign- or zero-extends it. It stalls the pipeline until the bus completes.

## Interface
- Parameters: none.
- `cpu_clk` input 1: clock; all state changes on rising edge.
- `cpu_rst` input 1: synchronous, active-high reset.
- `mem_valid` input 1: MEM stage holds a valid instruction.
- `mem_re` input 1: instruction is a load.
- `ram_we` input 4: store size code from CU: `RAM_WE_N`=4'b0000, `_B`=4'b0001, `_H`=4'b0011, `_W`=4'b1111.
- `ram_ext_op` input 3: load extension code from CU: `RAM_EXT_N`=0 (word), `_B`=1, `_BU`=2, `_H`=3, `_HU`=4.
- `mem_addr` input 32: effective address (ALU result).
- `mem_wdata` input 32: store data (rD value), low bits significant.
- `mem_rdata` output 32: extended load result.
- `mem_done` output 1: one-cycle completion pulse.
- `mem_stall` output 1: hold upstream stages.
- `mem_ale` output 1: address-alignment fault pulse (only with macro).
- `data_req` output 1, `data_wr` output 1, `data_wstrb` output 4, `data_addr` output 32, `data_wdata` output 32: bus request channel.
- `data_addr_ok` input 1, `data_data_ok` input 1, `data_rdata` input 32: bus response.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE → REQ when `mem_valid & (mem_re | ram_we!=0)`.
  - Latches the address, size, extension, write data and the `wr` flag. Write is `ram_we!=0` and takes priority if both are set.
  - Loads with no operation, or `mem_valid` low, stay in IDLE with no stall.
- REQ: `data_req`=1 with registered fields held stable. On `data_addr_ok`, move to WAIT.
- WAIT: `data_req`=0. On `data_data_ok`, capture `data_rdata` (loads only) and move to DONE. `data_data_ok` is ignored in every other state.
- DONE: `mem_done`=1 for exactly one cycle, then IDLE. The instruction is retired this cycle; the next request can be accepted in the following IDLE cycle.
- `data_addr` = `{mem_addr[31:2],2'b00}`. Lane select uses `off=mem_addr[1:0]`.
- Store `data_wstrb` = `ram_we << off`. It is truncated to 4 bits.
- Store `data_wdata`:
  - B: byte replicated ×4.
  - H: half replicated ×2.
  - W: passed through.
- Load extract:
  - B/BU: `rdata[8*off+:8]`, sign- or zero-extended.
  - H/HU: `rdata[16*off[1]+:16]`, extended.
  - N: full word.
- `mem_rdata` is registered. It is valid while `mem_done`=1 and holds its value until the next load completes. It is 0 after stores.
- `mem_stall` = `(state!=IDLE & state!=DONE) | (state==IDLE & accept)`. It is combinational in IDLE, so the accepting cycle already stalls.

## Timing
- Reset values:
  - state is IDLE.
  - `data_req`, `data_wr`, `mem_done`, `mem_stall` and `mem_ale` are 0.
  - `data_wstrb` is 0.
  - `data_addr`, `data_wdata` and `mem_rdata` are 0.
- Minimum latency with `addr_ok` and `data_ok` each one cycle after being awaited:
  - Accept at cycle 0.
  - REQ at cycle 1, `addr_ok` seen.
  - WAIT at cycle 2, `data_ok` seen.
  - `mem_done` at cycle 3.
  - 4 cycles total.
- `data_addr_ok` arriving in the first REQ cycle is legal.
- The bus guarantees that `data_data_ok` comes no earlier than the cycle after `addr_ok`.
- Request fields must not change while `data_req`=1 and `data_addr_ok`=0.
- Reset mid-operation returns to IDLE the next edge and drops `data_req`.
  - A late `data_data_ok` after reset is ignored.
  - No `mem_done` is produced for the aborted access.
- Inputs are sampled only on the accepting cycle. Changes to `mem_*` during stall are ignored.

## Configuration
- `MAU_ALIGN_CHECK_EN` defined:
  - Halfword with `off[0]=1`, or word with `off!=0`, is faulting.
  - In IDLE, the FSM goes directly to DONE with `mem_ale`=1 and `mem_done`=1 in that DONE cycle.
  - No bus request is issued. `mem_rdata` holds its previous value.
- Macro undefined:
  - `mem_ale` is tied to 0 and no check is made.
  - Misaligned strobes are truncated by the shift. Word loads ignore `off`.

## Test plan
- Word store, addr 0x1000_0004, wdata 0xDEAD_BEEF, `addr_ok`/`data_ok` one cycle each → `data_wr`=1, wstrb 4'b1111, addr 0x1000_0004, `mem_done` at cycle 3, stall cycles 0–2.
- st.b addr 0x…0003, wdata 0x0000_00A5 → wstrb 4'b1000, wdata 0xA5A5_A5A5.
- ld.b and ld.bu addr 0x…0002, `data_rdata` 0x1280_3344 → `mem_rdata` 0xFFFF_FF80 and 0x0000_0080.
- ld.h and ld.hu addr 0x…0002, rdata 0x8001_7FFF → 0xFFFF_8001 and 0x0000_8001; offset 0 ld.h → 0x0000_7FFF.
- `addr_ok` delayed 3 cycles, then `data_ok` delayed 2 → `data_req` and request fields stable through REQ, `mem_done` once, stall continuous.
- `cpu_rst` asserted in WAIT, then `data_data_ok` → IDLE, no `mem_done`.
  - With `MAU_ALIGN_CHECK_EN`: ld.w addr 0x…0002 → `mem_ale`=1, `mem_done`=1 at cycle 1, no `data_req`.
